lsu_stage: RTL and testbench

//  Memory-access stage directly downstream of exec: takes the ALU result/effective address,

---
 rtl/lsu_stage.sv | 185 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store stage between exec and writeback: one registered writeback record per accepted op.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into an immediate error record.
module lsu_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state, state_next;
  logic        op_load;
  logic [2:0]  op_funct3;
  logic [4:0]  op_rd;
  logic [1:0]  op_lo;
  logic [15:0] wait_cnt;
  logic        in_mem, trap, timeout_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign in_mem      = in_valid & (in_is_load | in_is_store);
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = in_mem & (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                          (in_funct3[1] & (in_addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_mem && !trap) state_next = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = op_load ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid || timeout_hit) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Store lane steering: narrow data is replicated so any byte lane carries it
  always_comb begin
    st_strb = 4'b1111;
    st_data = in_store_data;
    case (in_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << in_addr[1:0];
        st_data = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {in_addr[1], 1'b0};
        st_data = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = mem_rdata[{op_lo, 3'b000} +: 8];
  assign ld_half = op_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_val = mem_rdata;
    case (op_funct3[1:0])
      2'b00:   ld_val = op_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = op_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Op latch, memory command and writeback record; wb strobes default low each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_load   <= 1'b0;
      op_funct3 <= 3'b0;
      op_rd     <= 5'b0;
      op_lo     <= 2'b0;
      wait_cnt  <= 16'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wstrb <= 4'b0;
      mem_wdata <= 32'b0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_rd     <= 5'b0;
      wb_data   <= 32'b0;
      err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && !in_mem) begin
            wb_valid <= 1'b1;
            wb_data  <= in_addr;
            wb_rd    <= in_rd;
            wb_wen   <= (in_rd != 5'd0);
          end else if (trap) begin
            wb_valid <= 1'b1;
            err      <= 1'b1;
            wb_data  <= in_addr;
            wb_rd    <= in_rd;
          end else if (in_mem) begin
            op_load   <= in_is_load;
            op_funct3 <= in_funct3;
            op_rd     <= in_rd;
            op_lo     <= in_addr[1:0];
            mem_we    <= ~in_is_load;
            mem_addr  <= {in_addr[31:2], 2'b00};
            mem_wstrb <= in_is_load ? 4'b0000 : st_strb;
            mem_wdata <= st_data;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            if (op_load) begin
              wait_cnt <= 16'b0;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= op_rd;
              wb_data  <= 32'b0;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= ld_val;
            wb_wen   <= (op_rd != 5'd0);
          end else if (timeout_hit) begin
            wb_valid <= 1'b1;
            err      <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= 32'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios, then randomized ops against a reference model.
// Honours LSU_MISALIGN_TRAP_EN so the same bench covers both builds.
module tb_lsu_stage;

  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_addr, in_store_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_wen, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        auto_resp;
  logic        r_gnt, r_rvalid, d_gnt, d_rvalid;
  logic [31:0] r_rdata, d_rdata;

  assign mem_gnt    = auto_resp ? r_gnt    : d_gnt;
  assign mem_rvalid = auto_resp ? r_rvalid : d_rvalid;
  assign mem_rdata  = auto_resp ? r_rdata  : d_rdata;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic        err;
    logic [31:0] data;
    logic        chk;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        is_load;
    logic        to;
    logic [31:0] rdata;
  } rq_t;

  wb_t expq[$];
  rq_t rqq[$];
  int  checks = 0;
  int  errors = 0;

  lsu_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_rd(in_rd),
    .in_addr(in_addr), .in_store_data(in_store_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int szOf(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic int offOf(input logic [2:0] f3, input logic [31:0] a);
    int s = szOf(f3);
    if (s == 1) return int'(a[1:0]);
    if (s == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  // Shift the addressed bytes down, keep size*8 bits, then extend
  function automatic logic [31:0] expLoad(input logic [2:0] f3, input int off, input logic [31:0] rd_word);
    int sz = szOf(f3);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v = (rd_word >> (8 * off)) & mask;
    if (sz < 4 && !f3[2] && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idleInputs();
    in_valid = 1'b0;
    in_is_load = 1'b0;
    in_is_store = 1'b0;
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic to);
    wb_t e;
    rq_t r;
    int  sz, off;
    logic mis;
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_funct3     = f3;
    in_rd         = rd;
    in_addr       = addr;
    in_store_data = sdata;
    if (!in_ready) return;
    sz  = szOf(f3);
    off = offOf(f3, addr);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`ifndef LSU_MISALIGN_TRAP_EN
    mis = 1'b0;
`endif
    e.rd  = rd;
    e.chk = 1'b1;
    if (!ld && !st) begin
      e.wen = (rd != 5'd0); e.err = 1'b0; e.data = addr;
    end else if (mis) begin
      e.wen = 1'b0; e.err = 1'b1; e.data = addr;
    end else begin
      r.addr    = {addr[31:2], 2'b00};
      r.we      = !ld;
      r.is_load = ld;
      r.to      = to;
      r.rdata   = rdata;
      r.strb    = ld ? 4'b0000 : 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sdata[8*(i % sz) +: 8];
      if (!ld) begin
        e.wen = 1'b0; e.err = 1'b0; e.data = 32'h0; e.chk = 1'b0;
      end else if (to) begin
        e.wen = 1'b0; e.err = 1'b1; e.data = 32'h0;
      end else begin
        e.wen = (rd != 5'd0); e.err = 1'b0; e.data = expLoad(f3, off, rdata);
      end
      if (auto_resp) rqq.push_back(r);
    end
    expq.push_back(e);
  endtask

  // Every writeback pulse is matched, in order, against the model's queue
  wb_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("err_without_wb", 32'(err & ~wb_valid), 32'h0);
        if (wb_valid) begin
          if (expq.size() == 0) begin
            checkOutput("wb_unexpected", 32'h1, 32'h0);
          end else begin
            mon_e = expq.pop_front();
            checkOutput("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
            checkOutput("wb_wen", 32'(wb_wen), 32'(mon_e.wen));
            checkOutput("wb_err", 32'(err), 32'(mon_e.err));
            if (mon_e.chk) checkOutput("wb_data", wb_data, mon_e.data);
          end
        end
      end
    end
  end

  // Random-latency memory used in the randomized phase
  rq_t rsp;
  initial begin
    r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (auto_resp && !rst && mem_req && rqq.size() > 0) begin
        rsp = rqq.pop_front();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checkOutput("req_held", 32'(mem_req), 32'h1);
        checkOutput("req_addr", mem_addr, rsp.addr);
        checkOutput("req_we", 32'(mem_we), 32'(rsp.we));
        checkOutput("req_strb", 32'(mem_wstrb), 32'(rsp.strb));
        if (rsp.we) checkOutput("req_wdata", mem_wdata, rsp.wdata);
        r_gnt = 1'b1;
        @(negedge clk);
        r_gnt = 1'b0;
        if (rsp.is_load) begin
          if (!rsp.to) repeat ($urandom_range(0, 2)) @(negedge clk);
          else repeat (4) @(negedge clk);
          r_rvalid = 1'b1;
          r_rdata  = rsp.to ? $urandom : rsp.rdata;
          @(negedge clk);
          r_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] rd, input logic [31:0] rdata);
    applyStimulus(1'b1, 1'b0, f3, rd, addr, 32'h0, rdata, 1'b0);
    @(negedge clk);
    idleInputs();
    checkOutput("ld_req", 32'(mem_req), 32'h1);
    checkOutput("ld_addr", mem_addr, {addr[31:2], 2'b00});
    checkOutput("ld_we", 32'(mem_we), 32'h0);
    checkOutput("ld_strb", 32'(mem_wstrb), 32'h0);
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    checkOutput("ld_req_drop", 32'(mem_req), 32'h0);
    d_rvalid = 1'b1;
    d_rdata  = rdata;
    @(negedge clk);
    d_rvalid = 1'b0;
    checkOutput("ld_latency", 32'(wb_valid), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    auto_resp = 1'b0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = 32'h0;
    in_funct3 = 3'b0; in_rd = 5'b0; in_addr = 32'h0; in_store_data = 32'h0;
    idleInputs();

    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rst_wb_wen", 32'(wb_wen), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 32'h1);

    // Back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("alu_wb_pulse", 32'(wb_valid), 32'h1);
      checkOutput("alu_ready", 32'(in_ready), 32'h1);
    end
    idleInputs();
    @(negedge clk);

    // SB with a grant delayed two cycles
    applyStimulus(1'b0, 1'b1, 3'b000, 5'd7, 32'h103, 32'hAB, 32'h0, 1'b0);
    @(negedge clk);
    idleInputs();
    checkOutput("sb_ready_low", 32'(in_ready), 32'h0);
    checkOutput("sb_req_c1", 32'(mem_req), 32'h1);
    checkOutput("sb_addr", mem_addr, 32'h100);
    checkOutput("sb_strb", 32'(mem_wstrb), 32'h8);
    checkOutput("sb_wdata", mem_wdata, 32'hABABABAB);
    checkOutput("sb_we", 32'(mem_we), 32'h1);
    @(negedge clk);
    checkOutput("sb_req_c2", 32'(mem_req), 32'h1);
    checkOutput("sb_ready_low2", 32'(in_ready), 32'h0);
    @(negedge clk);
    checkOutput("sb_req_c3", 32'(mem_req), 32'h1);
    checkOutput("sb_addr_stable", mem_addr, 32'h100);
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    checkOutput("sb_wb_pulse", 32'(wb_valid), 32'h1);
    checkOutput("sb_req_drop", 32'(mem_req), 32'h0);
    checkOutput("sb_ready_back", 32'(in_ready), 32'h1);

    @(negedge clk);
    doLoad(3'b000, 32'h101, 5'd3, 32'h0000_8000);
    @(negedge clk);
    doLoad(3'b101, 32'h102, 5'd4, 32'hBEEF_0000);
    @(negedge clk);
    doLoad(3'b010, 32'h200, 5'd0, 32'h1234_5678);

    // Load timeout with a late rvalid that must be ignored
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd9, 32'h300, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    idleInputs();
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("to_no_wb_early", 32'(wb_valid), 32'h0);
      @(negedge clk);
    end
    checkOutput("to_wb_pulse", 32'(wb_valid), 32'h1);
    checkOutput("to_err", 32'(err), 32'h1);
    d_rvalid = 1'b1;
    d_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    d_rvalid = 1'b0;
    checkOutput("to_late_rvalid_ignored", 32'(wb_valid), 32'h0);

    // Reset while waiting for load data
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd10, 32'h400, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idleInputs();
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    #1;
    checkOutput("rstwait_req_drop", 32'(mem_req), 32'h0);
    checkOutput("rstwait_no_wb", 32'(wb_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstwait_ready", 32'(in_ready), 32'h1);
    checkOutput("rstwait_no_wb_after", 32'(wb_valid), 32'h0);

    // Misaligned word load
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 5'd11, 32'h102, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idleInputs();
    checkOutput("mis_no_req", 32'(mem_req), 32'h0);
    checkOutput("mis_wb", 32'(wb_valid), 32'h1);
    checkOutput("mis_err", 32'(err), 32'h1);
    checkOutput("mis_ready", 32'(in_ready), 32'h1);
`else
    doLoad(3'b010, 32'h102, 5'd11, 32'hCAFE_F00D);
`endif

    // Randomized phase
    @(negedge clk);
    idleInputs();
    auto_resp = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        idleInputs();
      end else begin
        int kind;
        logic ld, st;
        kind = $urandom_range(0, 2);
        ld = (kind == 1);
        st = (kind == 2) || (kind == 1 && $urandom_range(0, 1) == 1);
        applyStimulus(ld, st, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0));
      end
    end
    @(negedge clk);
    idleInputs();
    for (int k = 0; k < 200 && (expq.size() > 0 || rqq.size() > 0); k++) @(negedge clk);
    checkOutput("drain_wb_queue", 32'(expq.size()), 32'h0);
    checkOutput("drain_req_queue", 32'(rqq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
